register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 7 +
 rtl/register_bank.sv | 36 +++
 tb/tb_register_bank.sv | 111 +++++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// register_bank_pkg: processor-wide datapath widths shared by the register bank
//   DEF_WORD_LEN     - data width of every architectural register
//   DEF_REG_ADDR_LEN - register-address width (2**DEF_REG_ADDR_LEN registers)
package register_bank_pkg;
  localparam int DEF_WORD_LEN     = 32;
  localparam int DEF_REG_ADDR_LEN = 5;
endpackage

// File: rtl/register_bank.sv
// register_bank: 2-read/1-write register file with register 0 hardwired to zero
//   CLK             - write clock (rising edge)
//   RESET           - asynchronous active-high clear of every register
//   WRITE_ENABLE    - write DATA_IN to DESTINATION_REG on the next rising CLK
//   SOURCE_REG1/2   - combinational read addresses
//   DESTINATION_REG - write address (writes to 0 are dropped)
//   DATA_IN         - write data
//   DATA1/2_OUT_REG - contents of SOURCE_REG1/2, zero while RESET is high
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WORD_LEN     = DEF_WORD_LEN,
  parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    WRITE_ENABLE,
  input  logic [REG_ADDR_LEN-1:0] SOURCE_REG1,
  input  logic [REG_ADDR_LEN-1:0] SOURCE_REG2,
  input  logic [REG_ADDR_LEN-1:0] DESTINATION_REG,
  input  logic [WORD_LEN-1:0]     DATA_IN,
  output logic [WORD_LEN-1:0]     DATA1_OUT_REG,
  output logic [WORD_LEN-1:0]     DATA2_OUT_REG
);
  localparam int NUM_REGS = 2 ** REG_ADDR_LEN;
  logic [WORD_LEN-1:0] regs_q [NUM_REGS];
  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge CLK or posedge RESET)
    if (RESET)
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (WRITE_ENABLE && DESTINATION_REG != '0)
      regs_q[DESTINATION_REG] <= DATA_IN;
  // No write bypass: a same-cycle write only shows after the edge.
  assign DATA1_OUT_REG = regs_q[SOURCE_REG1];
  assign DATA2_OUT_REG = regs_q[SOURCE_REG2];
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: table-driven and directed checks of register_bank
module tb_register_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  s1 = '0, s2 = '0, dst = '0;
  logic [31:0] din = '0;
  logic [31:0] d1, d2;
  int checks = 0, fails = 0;

  typedef struct {
    logic [4:0]  s1, s2;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t vecs [96];

  register_bank dut (
    .CLK(clk), .RESET(rst), .WRITE_ENABLE(we),
    .SOURCE_REG1(s1), .SOURCE_REG2(s2), .DESTINATION_REG(dst),
    .DATA_IN(din), .DATA1_OUT_REG(d1), .DATA2_OUT_REG(d2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; dst = a; din = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      vecs[k]      = '{s1: k[4:0], s2: 5'd0, e1: 32'(k), e2: 32'd0};
      vecs[32 + k] = '{s1: 5'd0, s2: k[4:0], e1: 32'd0, e2: 32'(k)};
      vecs[64 + k] = '{s1: k[4:0], s2: k[4:0], e1: 32'(k), e2: 32'(k)};
    end
    s1 = 5'd5; s2 = 5'd31;
    #2;
    chk("reset_d1", d1, 32'd0);
    chk("reset_d2", d2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // preload register k with k, one write per cycle
    @(negedge clk);
    we = 1'b1;
    for (int k = 0; k < 32; k++) begin
      dst = k[4:0]; din = 32'(k);
      @(negedge clk);
    end
    we = 1'b0;
    for (int i = 0; i < 96; i++) begin
      s1 = vecs[i].s1; s2 = vecs[i].s2;
      #1;
      chk($sformatf("sweep%0d_d1", i), d1, vecs[i].e1);
      chk($sformatf("sweep%0d_d2", i), d2, vecs[i].e2);
    end
    wr(5'd0, 32'hDEADBEEF);
    s1 = 5'd0; s2 = 5'd0; #1;
    chk("r0_d1", d1, 32'd0);
    chk("r0_d2", d2, 32'd0);
    @(negedge clk);
    we = 1'b0; dst = 5'd7; din = 32'h1234;
    repeat (3) @(negedge clk);
    s1 = 5'd7; #1;
    chk("we0_r7", d1, 32'd7);
    @(negedge clk);
    s1 = 5'd9; we = 1'b1; dst = 5'd9; din = 32'hA5A5A5A5;
    @(posedge clk);
    #0;
    chk("r9_before", d1, 32'd9);
    #1;
    chk("r9_after", d1, 32'hA5A5A5A5);
    @(negedge clk);
    we = 1'b0;
    s1 = 5'd5; s2 = 5'd31; #1;
    chk("pre_rst_d1", d1, 32'd5);
    chk("pre_rst_d2", d2, 32'd31);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_d1", d1, 32'd0);
    chk("async_rst_d2", d2, 32'd0);
    @(negedge clk);
    we = 1'b1; dst = 5'd4; din = 32'h55;
    @(negedge clk);
    we = 1'b0; rst = 1'b0;
    s1 = 5'd4; #1;
    chk("write_in_rst", d1, 32'd0);
    @(negedge clk);
    we = 1'b1; dst = 5'd3; din = 32'h77;
    #2 rst = 1'b1;
    @(negedge clk);
    we = 1'b0; rst = 1'b0;
    s1 = 5'd3; #1;
    chk("rst_wins", d1, 32'd0);
    wr(5'd3, 32'h1111);
    s2 = 5'd3; #1;
    chk("post_rst_d1", d1, 32'h1111);
    chk("post_rst_d2", d2, 32'h1111);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
